// File: rtl/pattern_streamer.sv
// pattern_streamer: pops 64-bit pattern words from the output FIFO and streams them as framed 16-bit channel words
module pattern_streamer #(
  parameter int ROW_WORDS = 32,
  parameter int PAT_ROWS  = 176,
  parameter int CNT_W     = 32
) (
  input  logic        cam_clk,
  input  logic        fsm_rst,
  input  logic [31:0] Num_Pat,
  input  logic        seq_start,
  input  logic        pat_req,
  input  logic        pat_ready,
  input  logic [63:0] outfifo_dout,
  input  logic        outfifo_empty,
  output logic        outfifo_rd_en,
  output logic        read_start,
  output logic [15:0] pat_data,
  output logic        pat_valid,
  output logic        pat_row_start,
  output logic        pat_done,
  output logic        seq_done,
  output logic        underrun
);
  localparam int FIFO_WORDS = ROW_WORDS * PAT_ROWS / 4;
  localparam int WW = $clog2(ROW_WORDS);
  localparam int RW = $clog2(PAT_ROWS);
  localparam int FW = $clog2(FIFO_WORDS + 1);

  typedef enum logic [2:0] {S_IDLE, S_ARM, S_WAITREQ, S_FETCH, S_LOAD, S_SHIFT} state_t;

  state_t           state;
  logic [1:0]       lane_cnt;
  logic [WW-1:0]    word_cnt;
  logic [RW-1:0]    row_cnt;
  logic [FW-1:0]    fw_cnt;
  logic [CNT_W-1:0] pat_cnt, num_pat_q, pat_next;
  logic [63:0]      hold, skid;
  logic             skid_pend, skid_vld;
  logic             xfer, row_end, last_word, prefetch;

  assign pat_valid     = state == S_SHIFT;
  assign pat_data      = hold[{lane_cnt, 4'd0} +: 16];
  assign pat_row_start = pat_valid && word_cnt == '0;
  assign xfer          = pat_valid && pat_ready;
  assign row_end       = word_cnt == WW'(ROW_WORDS - 1);
  assign last_word     = row_end && row_cnt == RW'(PAT_ROWS - 1);
  assign pat_next      = pat_cnt + 1'b1;
  // the next word is fetched early at lane 2 so lane 0 of it follows lane 3 with no bubble; never past the pattern end
  assign prefetch      = xfer && lane_cnt == 2'd2 && fw_cnt != FW'(FIFO_WORDS) && !outfifo_empty;
  assign outfifo_rd_en = (state == S_FETCH && !outfifo_empty) || prefetch;

  // sequence / pattern control FSM with lane, word, row and pattern counters
  always_ff @(posedge cam_clk or posedge fsm_rst)
    if (fsm_rst) begin
      state      <= S_IDLE;
      lane_cnt   <= '0;
      word_cnt   <= '0;
      row_cnt    <= '0;
      fw_cnt     <= '0;
      pat_cnt    <= '0;
      num_pat_q  <= '0;
      hold       <= '0;
      skid       <= '0;
      skid_pend  <= 1'b0;
      skid_vld   <= 1'b0;
      read_start <= 1'b0;
      pat_done   <= 1'b0;
      seq_done   <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      pat_done  <= 1'b0;
      skid_pend <= prefetch;
      if (skid_pend) begin
        skid     <= outfifo_dout;
        skid_vld <= 1'b1;
      end
      case (state)
        S_IDLE:
          if (seq_start) begin
            num_pat_q  <= CNT_W'(Num_Pat);
            pat_cnt    <= '0;
            underrun   <= 1'b0;
            seq_done   <= Num_Pat == '0;
            read_start <= Num_Pat != '0;
            state      <= Num_Pat != '0 ? S_ARM : S_IDLE;
          end
        S_ARM:
          if (!outfifo_empty) begin
            read_start <= 1'b0;
            state      <= S_WAITREQ;
          end
        S_WAITREQ:
          if (pat_req && !pat_done) begin
            lane_cnt <= '0;
            word_cnt <= '0;
            row_cnt  <= '0;
            fw_cnt   <= '0;
            state    <= S_FETCH;
          end
        S_FETCH:
          if (!outfifo_empty) begin
            fw_cnt <= fw_cnt + 1'b1;
            state  <= S_LOAD;
          end else underrun <= 1'b1;
        S_LOAD: begin
          hold     <= outfifo_dout;
          lane_cnt <= '0;
          state    <= S_SHIFT;
        end
        S_SHIFT:
          if (xfer) begin
            lane_cnt <= lane_cnt + 2'd1;
            word_cnt <= row_end ? '0 : word_cnt + 1'b1;
            if (row_end) row_cnt <= row_cnt + 1'b1;
            if (prefetch) fw_cnt <= fw_cnt + 1'b1;
            if (lane_cnt == 2'd3) begin
              if (last_word) begin
                pat_done <= 1'b1;
                pat_cnt  <= pat_next;
                seq_done <= pat_next == num_pat_q;
                state    <= pat_next == num_pat_q ? S_IDLE : S_WAITREQ;
              end else if (skid_pend || skid_vld) begin
                hold     <= skid_pend ? outfifo_dout : skid;
                skid_vld <= 1'b0;
              end else state <= S_FETCH;
            end
          end
        default: state <= S_IDLE;
      endcase
    end
endmodule

// File: tb/tb_pattern_streamer.sv
// tb_pattern_streamer: scoreboard bench with a FIFO model and a lane-level reference of the pattern stream
module tb_pattern_streamer;
  localparam int ROW_WORDS = 32;
  localparam int PAT_ROWS  = 176;
  localparam int PW        = ROW_WORDS * PAT_ROWS;

  typedef struct {
    logic [15:0] d;
    bit          rs;
    bit          last;
  } exp_t;

  logic        cam_clk = 1'b0;
  logic        fsm_rst = 1'b1;
  logic [31:0] Num_Pat = '0;
  logic        seq_start = 1'b0, pat_req = 1'b0, pat_ready = 1'b0;
  logic [63:0] outfifo_dout = '0;
  logic        outfifo_empty = 1'b1;
  logic        outfifo_rd_en, read_start, pat_valid, pat_row_start, pat_done, seq_done, underrun;
  logic [15:0] pat_data;

  int checks = 0, failures = 0;
  int xfers = 0, rows = 0, pops = 0, rs_cycles = 0, rs_base = 0, cyc = 0;
  int first_x = 0, last_x = 0, rd_first = -1, lane_idx = 0;
  bit done_due = 0, stall_v = 0, pop_pend = 0;
  logic [15:0] stall_d = '0;
  logic [63:0] fifo_q[$];
  exp_t exp_q[$];

  pattern_streamer dut (
    .cam_clk(cam_clk), .fsm_rst(fsm_rst), .Num_Pat(Num_Pat), .seq_start(seq_start),
    .pat_req(pat_req), .pat_ready(pat_ready), .outfifo_dout(outfifo_dout),
    .outfifo_empty(outfifo_empty), .outfifo_rd_en(outfifo_rd_en), .read_start(read_start),
    .pat_data(pat_data), .pat_valid(pat_valid), .pat_row_start(pat_row_start),
    .pat_done(pat_done), .seq_done(seq_done), .underrun(underrun)
  );

  always #5 cam_clk = ~cam_clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge cam_clk) #1;
  endtask

  task automatic sample;
    @(negedge cam_clk) #1;
  endtask

  // each FIFO word becomes four expected lanes, low lane first; framing follows from the lane index
  task automatic push_words(input int n, input bit special);
    logic [63:0] w;
    exp_t e;
    for (int k = 0; k < n; k++) begin
      w = (special && k == 0) ? 64'h4444_3333_2222_1111 : {$urandom, $urandom};
      fifo_q.push_back(w);
      for (int l = 0; l < 4; l++) begin
        e.d    = w[16*l +: 16];
        e.rs   = (lane_idx % ROW_WORDS) == 0;
        e.last = (lane_idx % PW) == PW - 1;
        exp_q.push_back(e);
        lane_idx++;
      end
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_read_start"}, 64'(read_start), 64'd0);
    chk({tag, "_rd_en"}, 64'(outfifo_rd_en), 64'd0);
    chk({tag, "_pat_valid"}, 64'(pat_valid), 64'd0);
    chk({tag, "_pat_data"}, 64'(pat_data), 64'd0);
    chk({tag, "_row_start"}, 64'(pat_row_start), 64'd0);
    chk({tag, "_pat_done"}, 64'(pat_done), 64'd0);
    chk({tag, "_seq_done"}, 64'(seq_done), 64'd0);
    chk({tag, "_underrun"}, 64'(underrun), 64'd0);
  endtask

  // drives pat_ready until the monitor has seen the last word of the pattern
  task automatic wait_last(input bit rnd);
    logic [5:0] seqv = 6'b100111;
    for (int i = 0; i < 30000 && !done_due; i++) begin
      tick;
      pat_ready = !rnd ? 1'b1 : (i < 6 ? seqv[i] : ($urandom_range(0, 3) != 0));
      sample;
    end
    chk("last_word_seen", 64'(done_due), 64'd1);
  endtask

  task automatic wait_xfers(input int n);
    for (int i = 0; i < 30000 && xfers < n; i++) tick;
    chk("xfer_count_reached", 64'(xfers >= n), 64'd1);
  endtask

  task automatic request_pattern;
    xfers = 0;
    rows = 0;
    rd_first = -1;
    tick;
    pat_req = 1'b1;
    tick;
    pat_req = 1'b0;
  endtask

  // FIFO model: a pop seen during a cycle presents its data just after the next edge
  always @(posedge cam_clk) begin
    #1;
    if (pop_pend) begin
      chk("pop_nonempty", 64'(fifo_q.size() != 0), 64'd1);
      if (fifo_q.size() != 0) begin
        outfifo_dout = fifo_q.pop_front();
        pops++;
      end
    end
    #1;
    outfifo_empty = fifo_q.size() == 0;
  end

  // monitor: compares every transfer against the scoreboard and checks holds and done timing
  always @(negedge cam_clk) begin : mon
    exp_t e;
    bit nxt;
    pop_pend = outfifo_rd_en && !fsm_rst;
    if (!fsm_rst) begin
      if (outfifo_rd_en && rd_first < 0) rd_first = cyc;
      if (pat_done || done_due) chk("pat_done", 64'(pat_done), 64'(done_due));
      if (stall_v) begin
        chk("stall_valid", 64'(pat_valid), 64'd1);
        chk("stall_data", 64'(pat_data), 64'(stall_d));
      end
      nxt = 0;
      if (pat_valid && pat_ready) begin
        if (xfers == 0) first_x = cyc;
        last_x = cyc;
        xfers++;
        if (pat_row_start) rows++;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL extra_word actual=%0h expected=none", pat_data);
        end else begin
          e = exp_q.pop_front();
          chk("pat_data", 64'(pat_data), 64'(e.d));
          chk("row_start", 64'(pat_row_start), 64'(e.rs));
          nxt = e.last;
        end
      end
      done_due = nxt;
      stall_v = pat_valid && !pat_ready;
      stall_d = pat_data;
      if (read_start) rs_cycles++;
    end else begin
      done_due = 0;
      stall_v = 0;
    end
    cyc++;
  end

  initial begin
    #900000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) tick;
    sample;
    chk_idle("reset");
    tick;
    fsm_rst = 1'b0;
    // two-pattern sequence, read_start handshake, full-rate stream
    tick;
    Num_Pat = 2;
    seq_start = 1'b1;
    tick;
    seq_start = 1'b0;
    repeat (3) tick;
    sample;
    chk("read_start_arm", 64'(read_start), 64'd1);
    tick;
    lane_idx = 0;
    push_words(2 * PW / 4, 1'b1);
    sample;
    chk("read_start_hold", 64'(read_start), 64'd1);
    sample;
    chk("read_start_drop", 64'(read_start), 64'd0);
    rs_base = rs_cycles;
    pat_ready = 1'b1;
    request_pattern;
    wait_last(1'b0);
    tick;
    pat_req = 1'b1;
    sample;
    chk("p1_seq_done", 64'(seq_done), 64'd0);
    chk("p1_xfers", 64'(xfers), 64'(PW));
    chk("p1_no_bubble", 64'(last_x - first_x), 64'(PW - 1));
    chk("p1_pop_latency", 64'(first_x - rd_first), 64'd2);
    chk("p1_rows", 64'(rows), 64'(PAT_ROWS));
    chk("p1_pops", 64'(pops), 64'(PW / 4));
    tick;
    pat_req = 1'b0;
    repeat (6) tick;
    sample;
    chk("req_with_done_ignored", 64'(pat_valid), 64'd0);
    chk("req_with_done_no_pop", 64'(pops), 64'(PW / 4));
    // second pattern with stalls
    request_pattern;
    wait_last(1'b1);
    tick;
    pat_ready = 1'b1;
    sample;
    chk("p2_seq_done", 64'(seq_done), 64'd1);
    chk("p2_xfers", 64'(xfers), 64'(PW));
    chk("p2_rows", 64'(rows), 64'(PAT_ROWS));
    chk("p2_pops", 64'(pops), 64'(PW / 2));
    chk("p2_underrun", 64'(underrun), 64'd0);
    chk("read_start_once", 64'(rs_cycles), 64'(rs_base));
    request_pattern;
    repeat (5) tick;
    sample;
    chk("third_req_valid", 64'(pat_valid), 64'd0);
    chk("third_req_pops", 64'(pops), 64'(PW / 2));
    chk("sb_drained", 64'(exp_q.size()), 64'd0);
    // underrun and recovery
    lane_idx = 0;
    tick;
    Num_Pat = 1;
    seq_start = 1'b1;
    push_words(25, 1'b0);
    tick;
    seq_start = 1'b0;
    repeat (3) tick;
    sample;
    chk("ur_read_start_drop", 64'(read_start), 64'd0);
    chk("ur_seq_done_cleared", 64'(seq_done), 64'd0);
    request_pattern;
    wait_xfers(100);
    repeat (10) tick;
    sample;
    chk("ur_xfers_stopped", 64'(xfers), 64'd100);
    chk("ur_valid_low", 64'(pat_valid), 64'd0);
    chk("ur_flag", 64'(underrun), 64'd1);
    tick;
    push_words(PW / 4 - 25, 1'b0);
    wait_last(1'b1);
    tick;
    pat_ready = 1'b1;
    sample;
    chk("ur_xfers_total", 64'(xfers), 64'(PW));
    chk("ur_seq_done", 64'(seq_done), 64'd1);
    chk("ur_sticky", 64'(underrun), 64'd1);
    // reset mid-stream, then an empty sequence
    lane_idx = 0;
    tick;
    Num_Pat = 1;
    seq_start = 1'b1;
    push_words(PW / 4, 1'b0);
    tick;
    seq_start = 1'b0;
    repeat (3) tick;
    request_pattern;
    wait_xfers(2000);
    @(posedge cam_clk) #3;
    fsm_rst = 1'b1;
    fifo_q.delete();
    exp_q.delete();
    outfifo_empty = 1'b1;
    sample;
    chk_idle("midrst");
    repeat (2) tick;
    fsm_rst = 1'b0;
    rs_base = rs_cycles;
    tick;
    Num_Pat = 0;
    seq_start = 1'b1;
    tick;
    seq_start = 1'b0;
    sample;
    chk("zero_seq_done", 64'(seq_done), 64'd1);
    repeat (5) tick;
    sample;
    chk("zero_read_start", 64'(read_start), 64'd0);
    chk("zero_no_read_start", 64'(rs_cycles), 64'(rs_base));
    chk("zero_valid", 64'(pat_valid), 64'd0);
    chk("zero_seq_done_hold", 64'(seq_done), 64'd1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
